// File: rtl/better_neighbor_scan_if.sv
// Bus between the better-neighbour scan stage and its surroundings: scan control,
// cost memory read port, candidate buffer write port and results for the address stage.
interface better_neighbor_scan_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start_scan;
    logic [WIDTH-1:0] num_neighbors;
    logic [WIDTH-1:0] current_cost;
    logic [WIDTH-1:0] cost_addr;
    logic [WIDTH-1:0] cost_rdata;
    logic             cand_we;
    logic [WIDTH-1:0] cand_waddr;
    logic [WIDTH-1:0] cand_wdata;
    logic [WIDTH-1:0] better_neighbor_count;
    logic [WIDTH-1:0] which;
    logic             start_rng_address;
    logic             done_scan;
    logic             no_better;
    logic             busy;

    modport master (
        output start_scan, num_neighbors, current_cost, cost_rdata,
        input  cost_addr, cand_we, cand_waddr, cand_wdata, better_neighbor_count,
               which, start_rng_address, done_scan, no_better, busy
    );

    modport slave (
        input  start_scan, num_neighbors, current_cost, cost_rdata,
        output cost_addr, cand_we, cand_waddr, cand_wdata, better_neighbor_count,
               which, start_rng_address, done_scan, no_better, busy
    );
endinterface

// File: rtl/better_neighbor_scan.sv
// Walks the neighbour cost memory, compacts the indices of neighbours that beat the
// current cost into the candidate buffer, then hands count and a random word downstream.
module better_neighbor_scan #(
    parameter int unsigned WIDTH     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter bit          STRICT    = 1'b1
) (
    input logic                   clock,
    input logic                   nrst,
    better_neighbor_scan_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] cur_q;
    logic [WIDTH-1:0] count;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_idx;
    logic [15:0]      lfsr;
    logic             lfsr_fb;
    logic             is_better;
    logic             last_addr;

    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign is_better = STRICT ? (bus.cost_rdata < cur_q) : (bus.cost_rdata <= cur_q);
    assign last_addr = (n_q == '0) || (bus.cost_addr == n_q - WIDTH'(1));

    // NOTE: state and every other flop use <= so all registers update together at the edge.
    always_ff @(posedge clock) begin
        if (!nrst) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start_scan) next_state = SCAN;
            SCAN:    if (last_addr)      next_state = DRAIN;
            // The read issued for the last address lands while rd_valid is high.
            DRAIN:   if (!rd_valid)      next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            lfsr                      <= LFSR_SEED;
            n_q                       <= '0;
            cur_q                     <= '0;
            count                     <= '0;
            rd_valid                  <= 1'b0;
            rd_idx                    <= '0;
            bus.cost_addr             <= '0;
            bus.cand_we               <= 1'b0;
            bus.cand_waddr            <= '0;
            bus.cand_wdata            <= '0;
            bus.better_neighbor_count <= '0;
            bus.which                 <= '0;
            bus.start_rng_address     <= 1'b0;
            bus.done_scan             <= 1'b0;
            bus.no_better             <= 1'b0;
            bus.busy                  <= 1'b0;
        end else begin
            lfsr                  <= {lfsr[14:0], lfsr_fb};
            bus.done_scan         <= 1'b0;
            bus.start_rng_address <= 1'b0;
            bus.busy              <= (next_state != IDLE);

            // Read pipe: the address presented now returns on cost_rdata next cycle.
            rd_valid    <= (state == SCAN) && (n_q != '0);
            rd_idx      <= bus.cost_addr;
            bus.cand_we <= rd_valid && is_better;
            if (rd_valid && is_better) begin
                bus.cand_waddr <= count;
                bus.cand_wdata <= rd_idx;
                count          <= count + WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.start_scan) begin
                        n_q           <= bus.num_neighbors;
                        cur_q         <= bus.current_cost;
                        count         <= '0;
                        bus.no_better <= 1'b0;
                        bus.cost_addr <= '0;
                    end
                end
                SCAN: begin
                    if (!last_addr) bus.cost_addr <= bus.cost_addr + WIDTH'(1);
                end
                DRAIN: begin
                    if (!rd_valid) begin
                        bus.done_scan             <= 1'b1;
                        bus.better_neighbor_count <= count;
                        bus.which                 <= WIDTH'(lfsr);
                        // A zero count would hand the address stage a zero divisor.
                        bus.start_rng_address     <= (count != '0);
                        bus.no_better             <= (count == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_better_neighbor_scan.sv
// Directed bench: a strict and a non-strict instance run side by side against a scoreboard
// of expected candidate writes, done timing, count, flags and the LFSR word.
module tb_better_neighbor_scan;

    logic clock;
    logic nrst;

    better_neighbor_scan_if #(.WIDTH(16)) bus_s ();
    better_neighbor_scan_if #(.WIDTH(16)) bus_l ();

    better_neighbor_scan #(.WIDTH(16), .LFSR_SEED(16'hACE1), .STRICT(1'b1)) u_dut_strict (
        .clock(clock),
        .nrst (nrst),
        .bus  (bus_s)
    );

    better_neighbor_scan #(.WIDTH(16), .LFSR_SEED(16'hACE1), .STRICT(1'b0)) u_dut_loose (
        .clock(clock),
        .nrst (nrst),
        .bus  (bus_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int slot;
        int idx;
        int cyc;
    } wr_t;

    wr_t         q_s[$];
    wr_t         q_l[$];
    logic [15:0] mem [16];
    int          checks = 0;
    int          errors = 0;
    int          edges_since_rst = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_after(input int k);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < k; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return l;
    endfunction

    task automatic tick();
        @(posedge clock);
        if (nrst) edges_since_rst++;
        else      edges_since_rst = 0;
        @(negedge clock);
    endtask

    task automatic set_inputs(input logic start, input logic [15:0] n, input logic [15:0] cur);
        bus_s.start_scan    = start;
        bus_l.start_scan    = start;
        bus_s.num_neighbors = n;
        bus_l.num_neighbors = n;
        bus_s.current_cost  = cur;
        bus_l.current_cost  = cur;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " strict outputs"},
              {bus_s.cost_addr, bus_s.cand_we, bus_s.cand_waddr, bus_s.cand_wdata,
               bus_s.start_rng_address, bus_s.done_scan, bus_s.no_better, bus_s.busy}, '0);
        check({tag, " strict count/which"}, {bus_s.better_neighbor_count, bus_s.which}, '0);
        check({tag, " loose outputs"},
              {bus_l.cost_addr, bus_l.cand_we, bus_l.cand_waddr, bus_l.cand_wdata,
               bus_l.start_rng_address, bus_l.done_scan, bus_l.no_better, bus_l.busy}, '0);
        check({tag, " loose count/which"}, {bus_l.better_neighbor_count, bus_l.which}, '0);
    endtask

    // Called at the negedge of the start cycle (cycle 0); returns at the negedge of cycle N+4.
    task automatic run_scan(input string tag, input int n, input logic [15:0] cur);
        int          exp_s = 0;
        int          exp_l = 0;
        int          done_c = -1;
        int          early_rng = 0;
        int          busy_drop = 0;
        logic [15:0] pend_s;
        logic [15:0] pend_l;
        logic [15:0] exp_which;
        wr_t         e;

        for (int i = 0; i < n; i++) begin
            if (mem[i] < cur) begin
                q_s.push_back('{slot: exp_s, idx: i, cyc: i + 3});
                exp_s++;
            end
            if (mem[i] <= cur) begin
                q_l.push_back('{slot: exp_l, idx: i, cyc: i + 3});
                exp_l++;
            end
        end

        set_inputs(1'b1, 16'(n), cur);
        pend_s = bus_s.cost_addr;
        pend_l = bus_l.cost_addr;
        tick();
        set_inputs(1'b0, 16'(n), cur);

        for (int c = 1; c <= n + 10; c++) begin
            bus_s.cost_rdata = mem[pend_s[3:0]];
            bus_l.cost_rdata = mem[pend_l[3:0]];
            pend_s = bus_s.cost_addr;
            pend_l = bus_l.cost_addr;
            if (bus_s.cand_we) begin
                if (q_s.size() == 0) check({tag, " strict unexpected write"}, 1, 0);
                else begin
                    e = q_s.pop_front();
                    check({tag, " strict slot"}, bus_s.cand_waddr, e.slot);
                    check({tag, " strict idx"},  bus_s.cand_wdata, e.idx);
                    check({tag, " strict write cycle"}, c, e.cyc);
                end
            end
            if (bus_l.cand_we) begin
                if (q_l.size() == 0) check({tag, " loose unexpected write"}, 1, 0);
                else begin
                    e = q_l.pop_front();
                    check({tag, " loose slot"}, bus_l.cand_waddr, e.slot);
                    check({tag, " loose idx"},  bus_l.cand_wdata, e.idx);
                    check({tag, " loose write cycle"}, c, e.cyc);
                end
            end
            if ((bus_s.start_rng_address || bus_l.start_rng_address) && !bus_s.done_scan) early_rng++;
            if (!bus_s.busy || !bus_l.busy) busy_drop++;
            if (bus_s.done_scan) begin
                done_c = c;
                break;
            end
            tick();
        end

        exp_which = lfsr_after(edges_since_rst - 1);
        check({tag, " done cycle"}, done_c, n + 3);
        check({tag, " loose done"}, bus_l.done_scan, 1);
        check({tag, " strict writes left"}, q_s.size(), 0);
        check({tag, " loose writes left"}, q_l.size(), 0);
        check({tag, " rng before done"}, early_rng, 0);
        check({tag, " busy dropped"}, busy_drop, 0);
        check({tag, " strict count"}, bus_s.better_neighbor_count, exp_s);
        check({tag, " loose count"}, bus_l.better_neighbor_count, exp_l);
        check({tag, " strict rng"}, bus_s.start_rng_address, exp_s > 0);
        check({tag, " loose rng"}, bus_l.start_rng_address, exp_l > 0);
        check({tag, " strict no_better"}, bus_s.no_better, exp_s == 0);
        check({tag, " loose no_better"}, bus_l.no_better, exp_l == 0);
        check({tag, " strict which"}, bus_s.which, exp_which);
        check({tag, " loose which"}, bus_l.which, exp_which);
        q_s.delete();
        q_l.delete();

        // start_scan on the done_scan cycle must be ignored.
        set_inputs(1'b1, 16'(n), cur);
        tick();
        set_inputs(1'b0, 16'(n), cur);
        check({tag, " start on done ignored"}, {bus_s.busy, bus_l.busy}, 2'b00);
        check({tag, " pulses cleared"},
              {bus_s.done_scan, bus_s.start_rng_address, bus_l.done_scan, bus_l.start_rng_address}, '0);
        check({tag, " strict count held"}, bus_s.better_neighbor_count, exp_s);
        check({tag, " strict which held"}, bus_s.which, exp_which);
        check({tag, " no_better held"}, {bus_s.no_better, bus_l.no_better}, {exp_s == 0, exp_l == 0});
    endtask

    initial begin
        int done_seen;

        nrst = 1'b0;
        set_inputs(1'b0, '0, '0);
        bus_s.cost_rdata = '0;
        bus_l.cost_rdata = '0;
        foreach (mem[i]) mem[i] = 16'd100;
        @(negedge clock);
        tick();
        tick();
        check_zero("reset");
        nrst = 1'b1;
        tick();

        // Costs 12,7,10,3 against 10: strict finds 1,3; non-strict finds 1,2,3.
        mem[0] = 16'd12; mem[1] = 16'd7; mem[2] = 16'd10; mem[3] = 16'd3;
        run_scan("n4", 4, 16'd10);

        // Accepted back-to-back: cost equal to current is better only when non-strict.
        mem[0] = 16'd10; mem[1] = 16'd15; mem[2] = 16'd20;
        run_scan("n3", 3, 16'd10);

        run_scan("n0", 0, 16'd50);

        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        mem[0] = 16'd0;
        run_scan("after reset n1", 1, 16'd5);

        // Mid-scan start is ignored, then reset aborts the scan.
        foreach (mem[i]) mem[i] = 16'd100;
        bus_s.cost_rdata = 16'd100;
        bus_l.cost_rdata = 16'd100;
        set_inputs(1'b1, 16'd5, 16'd5);
        tick();
        set_inputs(1'b0, 16'd5, 16'd5);
        tick();
        set_inputs(1'b1, 16'd5, 16'd5);
        tick();
        set_inputs(1'b0, 16'd5, 16'd5);
        check("abort addr continues", {bus_s.cost_addr, bus_l.cost_addr}, {16'd2, 16'd2});
        check("abort busy", {bus_s.busy, bus_l.busy}, 2'b11);
        tick();
        nrst = 1'b0;
        tick();
        check_zero("abort");
        nrst = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus_s.done_scan || bus_l.done_scan || bus_s.start_rng_address || bus_l.start_rng_address)
                done_seen++;
        end
        check("abort no done", done_seen, 0);

        mem[0] = 16'd5; mem[1] = 16'd2;
        run_scan("fresh n2", 2, 16'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
